// File: rtl/deserializer.sv
// deserializer: serial-in/parallel-out receiver for the isolator-board byte link.
//
// Recovers 8-bit words shifted MSB-first on ser_clk/ser_data, framed by the active-low
// ser_load_n strobe, and queues them in a small byte FIFO with a valid/ready output.
// All link inputs are asynchronous to clk and are brought in through synchronizer chains.
//
// Optional build macro:
//   DESERIALIZER_FRAME_CHECK_EN - when defined, frame_err flags short frames and clock
//   edges that arrive after a complete byte. When undefined, frame_err is tied low.
//   The data path behaves identically in both builds.

module deserializer #(
  parameter int unsigned FIFO_DEPTH  = 4,  // power of 2, minimum 2
  parameter int unsigned SYNC_STAGES = 2   // minimum 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ser_clk,
  input  logic                          ser_data,
  input  logic                          ser_load_n,
  output logic [7:0]                    dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  // Receiver FSM encoding
  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // --------------------------------------------------------------------------
  // Input synchronization
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [SYNC_STAGES-1:0] load_n_sync_q;
  logic                   clk_prev_q;

  logic ser_rise;
  logic data_s;
  logic load_n_s;

  // Synchronize all three link inputs through equal-length chains so the data bit
  // seen alongside a detected edge is the one the transmitter presented at that edge.
  // Clock and load chains reset high so that neither a link clock already high nor a
  // frame already in progress looks like a fresh edge or a fresh strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q    <= '1;
      data_sync_q   <= '0;
      load_n_sync_q <= '1;
      clk_prev_q    <= 1'b1;
    end else begin
      clk_sync_q    <= {clk_sync_q[SYNC_STAGES-2:0], ser_clk};
      data_sync_q   <= {data_sync_q[SYNC_STAGES-2:0], ser_data};
      load_n_sync_q <= {load_n_sync_q[SYNC_STAGES-2:0], ser_load_n};
      clk_prev_q    <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ser_rise = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign load_n_s = load_n_sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Framing state machine and shift register
  // --------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       done_q, done_d;

  // Next-state: load low always restarts the frame and drops any partial byte;
  // the 8th edge completes the byte and parks in S_WAIT until the next strobe.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    if (!load_n_s) begin
      state_d   = S_LOAD;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_LOAD: begin
          state_d = S_SHIFT;
          // Load release and first edge can be seen in the same cycle; keep that bit.
          if (ser_rise) begin
            shift_d   = {shift_q[6:0], data_s};
            bit_cnt_d = 4'd1;
          end
        end
        S_SHIFT: begin
          if (ser_rise) begin
            shift_d   = {shift_q[6:0], data_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_d = S_WAIT;
              done_d  = 1'b1;
            end
          end
        end
        S_WAIT: begin
          state_d = S_WAIT;
        end
        default: begin
          state_d = S_WAIT;
        end
      endcase
    end
  end

  // FSM state; reset parks in S_WAIT so only a full, strobed frame is ever captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_WAIT;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Push stage
  // --------------------------------------------------------------------------
  logic       push_q;
  logic [7:0] push_byte_q;

  // Hand the completed byte to the FIFO one cycle after completion; shift_q is held
  // in S_WAIT/S_LOAD, so it still carries the byte here.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_q      <= 1'b0;
      push_byte_q <= 8'h00;
    end else begin
      push_q      <= done_q;
      push_byte_q <= shift_q;
    end
  end

  // --------------------------------------------------------------------------
  // Byte FIFO with registered head
  // --------------------------------------------------------------------------
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic            overflow_q, overflow_d;

  logic pop;
  logic full;
  logic push_ok;

  assign pop     = dout_valid_q & dout_ready;
  assign full    = (count_q == FullCnt);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push_q & (~full | pop);

  // Next FIFO state; dout is loaded with the head that will exist after this edge,
  // so a consumer holding ready high sees a new byte every cycle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    count_d    = count_q + CntW'(push_ok) - CntW'(pop);
    overflow_d = overflow_q | (push_q & full & ~pop);
    dout_d     = dout_q;
    if (count_d != '0) begin
      // New head is the byte being written this cycle (FIFO empty or draining to it).
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        dout_d = push_byte_q;
      end else begin
        dout_d = mem_q[rd_ptr_d];
      end
    end
    dout_valid_d = (count_d != '0);
  end

  // FIFO control registers and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset since only written entries are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_byte_q;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  // --------------------------------------------------------------------------
  // Framing error
  // --------------------------------------------------------------------------
`ifdef DESERIALIZER_FRAME_CHECK_EN
  logic frame_err_q;
  logic short_frame;
  logic extra_edge;

  assign short_frame = ~load_n_s & (state_q == S_SHIFT) & (bit_cnt_q != 4'd0);
  assign extra_edge  = load_n_s & (state_q == S_WAIT) & ser_rise;

  // Sticky flag for frames cut short and edges beyond the 8th bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q <= 1'b0;
    end else if (short_frame || extra_edge) begin
      frame_err_q <= 1'b1;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed scenarios plus randomized frames,
// compared against a cycle-level queue model of the byte stream.

module tb_deserializer;

  localparam int unsigned Depth = 4;
  localparam int unsigned Sync  = 2;

`ifdef DESERIALIZER_FRAME_CHECK_EN
  localparam bit FeOn = 1'b1;
`else
  localparam bit FeOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ser_clk = 1'b0;
  logic       ser_data = 1'b0;
  logic       ser_load_n = 1'b1;
  logic       dout_ready = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [$clog2(Depth):0] fifo_count;
  logic       overflow;
  logic       frame_err;

  deserializer #(
    .FIFO_DEPTH (Depth),
    .SYNC_STAGES(Sync)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_clk   (ser_clk),
    .ser_data  (ser_data),
    .ser_load_n(ser_load_n),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of delivered bytes, pushes scheduled at the
  // documented latency, pops whenever the queue is non-empty and ready is high.
  // ---------------------------------------------------------------------------
  int         cyc = 0;
  logic [7:0] mq[$];
  int         sched_cyc[$];
  logic [7:0] sched_byte[$];
  bit         m_ovf = 1'b0;
  logic [7:0] m_dout = 8'h00;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    bit         pop;
    bit         push;
    bit         was_full;
    logic [7:0] b;
    cyc++;
    if (reset) begin
      mq.delete();
      sched_cyc.delete();
      sched_byte.delete();
      m_ovf  = 1'b0;
      m_dout = 8'h00;
      chk_en = 1'b1;
    end else begin
      was_full = (mq.size() == Depth);
      pop      = (mq.size() != 0) && (dout_ready === 1'b1);
      push     = 1'b0;
      b        = 8'h00;
      if (sched_cyc.size() != 0 && sched_cyc[0] == cyc) begin
        push = 1'b1;
        b    = sched_byte.pop_front();
        void'(sched_cyc.pop_front());
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (was_full && !pop) m_ovf = 1'b1;
        else mq.push_back(b);
      end
      if (mq.size() != 0) m_dout = mq[0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", {31'd0, dout_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
      check("count", {29'd0, fifo_count}, mq.size());
      check("dout", {24'd0, dout}, {24'd0, m_dout});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  // Consumer: 0 = hold ready_val, 1 = random, 2 = single pulse for edge pop_at.
  int ready_mode = 0;
  bit ready_val = 1'b0;
  int pop_at = -1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       dout_ready = ready_val;
      1:       dout_ready = 1'($urandom_range(0, 1));
      default: dout_ready = (cyc + 1 == pop_at);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Link stimulus with frame bookkeeping (which bits form a byte, which are errors)
  // ---------------------------------------------------------------------------
  bit         armed = 1'b0;
  int         nbits = 0;
  logic [7:0] acc = 8'h00;
  bit         fe_exp = 1'b0;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fe_hit();
    if (FeOn) fe_exp = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_clk(2);
    reset  = 1'b0;
    armed  = 1'b0;
    nbits  = 0;
    fe_exp = 1'b0;
  endtask

  task automatic load_strobe();
    if (armed && nbits > 0) fe_hit();
    ser_load_n = 1'b0;
    wait_clk(6);
    ser_load_n = 1'b1;
    armed = 1'b1;
    nbits = 0;
    wait_clk(2);
  endtask

  task automatic send_bit(input logic b);
    int t;
    ser_data = b;
    wait_clk(2);
    ser_clk = 1'b1;
    if (armed) begin
      acc = {acc[6:0], b};
      nbits++;
      if (nbits == 8) begin
        // First clk edge sampling this rise is cyc+1; byte visible Sync+2 edges later.
        t = cyc + Sync + 3;
        sched_cyc.push_back(t);
        sched_byte.push_back(acc);
        if (ready_mode == 2) pop_at = t;
        armed = 1'b0;
      end
    end else begin
      fe_hit();
    end
    wait_clk($urandom_range(3, 6));
    ser_clk = 1'b0;
    wait_clk($urandom_range(3, 6));
  endtask

  task automatic send_frame(input logic [7:0] v, input int n);
    load_strobe();
    for (int i = 0; i < n; i++) send_bit(v[7-i]);
  endtask

  task automatic drain();
    ready_mode = 0;
    ready_val  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (fifo_count == 0) break;
      wait_clk(1);
    end
    ready_val = 1'b0;
    wait_clk(2);
    check("drain_empty", {29'd0, fifo_count}, 32'd0);
  endtask

  initial begin
    logic [7:0] burst [5];
    logic [7:0] fill [4];
    logic [7:0] v;
    int         r;
    burst = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C};
    fill  = '{8'h11, 8'h22, 8'h33, 8'h44};

    do_reset();
    wait_clk(1);
    check("rst_dout", {24'd0, dout}, 32'h00);
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);

    // Single byte
    send_frame(8'hA5, 8);
    wait_clk(6);
    check("a5_count", {29'd0, fifo_count}, 32'd1);
    check("a5_dout", {24'd0, dout}, 32'hA5);
    check("a5_valid", {31'd0, dout_valid}, 32'd1);
    drain();

    // Overflow: five bytes into a four-entry FIFO
    for (int i = 0; i < 5; i++) send_frame(burst[i], 8);
    wait_clk(6);
    check("ovf_count", {29'd0, fifo_count}, 32'd4);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_head", {24'd0, dout}, 32'h01);
    drain();
    check("ovf_last", {24'd0, dout}, 32'h00);

    // Short frame followed by a full one
    send_frame(8'hE7, 5);
    send_frame(8'h5A, 8);
    wait_clk(6);
    check("short_count", {29'd0, fifo_count}, 32'd1);
    check("short_dout", {24'd0, dout}, 32'h5A);
    check("short_fe", {31'd0, frame_err}, {31'd0, FeOn});
    drain();

    // Ten edges in one frame
    send_frame(8'hC3, 8);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_clk(6);
    check("extra_count", {29'd0, fifo_count}, 32'd1);
    check("extra_dout", {24'd0, dout}, 32'hC3);
    check("extra_fe", {31'd0, frame_err}, {31'd0, FeOn});
    drain();

    // Reset mid-frame, remaining edges must not form a byte
    v = 8'hE1;
    send_frame(v, 4);
    do_reset();
    for (int i = 4; i < 8; i++) send_bit(v[7-i]);
    wait_clk(8);
    check("midrst_count", {29'd0, fifo_count}, 32'd0);
    check("midrst_ovf", {31'd0, overflow}, 32'd0);
    check("midrst_fe", {31'd0, frame_err}, {31'd0, FeOn});
    send_frame(8'h96, 8);
    wait_clk(6);
    check("midrst_next", {24'd0, dout}, 32'h96);
    drain();

    // Full FIFO with a pop on the very cycle the next byte lands
    for (int i = 0; i < 4; i++) send_frame(fill[i], 8);
    wait_clk(6);
    check("full_count", {29'd0, fifo_count}, 32'd4);
    ready_mode = 2;
    send_frame(8'h77, 8);
    wait_clk(6);
    ready_mode = 0;
    pop_at = -1;
    check("pushpop_count", {29'd0, fifo_count}, 32'd4);
    check("pushpop_ovf", {31'd0, overflow}, 32'd0);
    check("pushpop_head", {24'd0, dout}, 32'h22);
    drain();
    check("pushpop_last", {24'd0, dout}, 32'h77);

    // Randomized frames with a random consumer
    do_reset();
    ready_mode = 1;
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      v = 8'($urandom);
      if (r == 0) begin
        send_frame(v, $urandom_range(1, 7));
      end else begin
        send_frame(v, 8);
        if (r == 1) begin
          for (int j = 0; j < $urandom_range(1, 3); j++) send_bit(1'($urandom));
        end
      end
    end
    wait_clk(8);
    drain();
    check("rand_fe", {31'd0, frame_err}, {31'd0, fe_exp});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deserializer.md
# deserializer

Serial-in/parallel-out receiver for the isolator-board byte link: recovers 8-bit words shifted MSB-first on a `ser_clk`/`ser_data` pair, framed by an active-low load strobe. All three link inputs are asynchronous to the FPGA clock, so the block samples them on the system clock. It buffers received bytes in a small FIFO with a valid/ready output. It is the receiving end for the parallel-load shift-register transmitter on the same link.

## Interface
- `FIFO_DEPTH`, 4: byte FIFO entries; power of 2, minimum 2.
- `SYNC_STAGES`, 2: synchronizer flops per link input; minimum 2.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ser_clk` in 1: link shift clock, asynchronous to `clk`; data is valid at its rising edge.
- `ser_data` in 1: link serial data, MSB first.
- `ser_load_n` in 1: frame strobe, active-low; low = transmitter loading, high = shifting.
- `dout` out 8: FIFO head byte.
- `dout_valid` out 1: FIFO non-empty.
- `dout_ready` in 1: consumer accepts `dout` when this and `dout_valid` are both high.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; a completed byte was dropped because the FIFO was full.
- `frame_err` out 1: sticky framing error (see Configuration).

## Operation
- Synchronization: each link input passes through `SYNC_STAGES` flops. One extra flop on `ser_clk` provides rising-edge detection. Data and load are delayed by the same number of stages, so the data bit sampled is aligned with the detected edge.
- State machine (`S_LOAD`, `S_SHIFT`, `S_WAIT`):
  - `S_LOAD`: bit counter = 0, shift register holds. Goes to `S_SHIFT` when the synchronized load is high.
  - `S_SHIFT`: each detected rising edge shifts the synchronized data in at the LSB and increments the counter. On the 8th edge, the assembled byte goes to the FIFO and the state goes to `S_WAIT`.
  - `S_WAIT`: further edges are ignored (counted as extra bits for the framing check).
  - Any state goes to `S_LOAD` whenever the synchronized load is low. A partial byte (1–7 bits) is discarded, never pushed.
- Reset puts the FSM in `S_WAIT`. The first byte after reset is accepted only after a low→high load strobe, so a frame already in progress is never captured partially.
- FIFO behaviour:
  - Pop when `dout_valid && dout_ready`.
  - Push when full without a same-cycle pop: byte dropped, `overflow` set.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Push and pop in the same cycle while empty: push only (there is no read-through).
- Pointers wrap modulo `FIFO_DEPTH`. `fifo_count` is saturation-free because pushes are gated.
- Reset values: `dout`=0x00, `dout_valid`=0, `fifo_count`=0, `overflow`=0, `frame_err`=0. The FIFO is emptied and pointers are set to 0.
- `dout` is registered; it shows the head entry and holds its value while empty.

## Timing
- Input constraints: `ser_clk` high and low phases are each ≥ `SYNC_STAGES`+1 `clk` periods. `ser_data` is stable from one `clk` period before the `ser_clk` rise to one period after. `ser_load_n` changes only while `ser_clk` is low.
- Latency: with an empty FIFO, `dout_valid` rises `SYNC_STAGES`+2 `clk` edges after the first `clk` edge that samples `ser_clk` high for the 8th bit.
- Throughput: one byte per frame. A frame takes 8 `ser_clk` periods plus at least `SYNC_STAGES`+1 `clk` periods with load low.
- `dout` and `dout_valid` update on the `clk` edge after a pop. A consumer holding `dout_ready` high drains one byte per cycle.
- `overflow` and `frame_err` set on the cycle of the offending event and clear only on `reset`.

## Configuration
- `DESERIALIZER_FRAME_CHECK_EN` defined:
  - `frame_err` is set when load goes low after 1–7 bits of a frame.
  - `frame_err` is set when a rising `ser_clk` edge is detected in `S_WAIT`.
  - Both events still discard or ignore the bits, as in normal operation.
- Not defined: `frame_err` is tied to 0. Partial frames are discarded and extra edges ignored silently. Data-path behaviour is identical in both builds.

## Test plan
- Reset, then load strobe, then shift 0xA5 → one `dout_valid` pulse-train entry 0xA5 at the specified latency; `fifo_count`=1.
- Frames 0x01, 0x80, 0xFF, 0x00, 0x3C with `dout_ready`=0 and `FIFO_DEPTH`=4 → `fifo_count`=4 and `overflow`=1. Drain with `dout_ready`=1 → 0x01, 0x80, 0xFF, 0x00, one per cycle.
- Load low after 5 bits, then a full 0x5A frame → only 0x5A is delivered; `frame_err`=1 with the macro, 0 without.
- 10 `ser_clk` edges in one frame carrying 0xC3 followed by 2 extra bits → one byte 0xC3; `frame_err`=1 with the macro.
- Assert `reset` after 4 bits of a frame, then continue the remaining 4 edges with no new load → no byte; the next full frame 0x96 is delivered.
- FIFO full with `dout_ready`=1 on the same cycle as the 8th bit completing 0x77 → no overflow; `fifo_count` stays 4; 0x77 emerges last.
